ws2812_uart_strip_router: RTL and testbench

// - Parametrised N-channel WS2812 controller fed by the UART receiver byte stream.
// - Parses 4-byte frames {channel, G, R, B} and stores the colour in that channel's pixel register.
// - Each channel has its own serializer. It continuously refreshes its strip with PIXELS copies of the stored GRB word, then a latch gap.
// - Replaces the fixed 4-strip arbiter/demux path; channel selection is carried in-band.

---
 rtl/ws2812_uart_strip_router.sv | 186 ++++++++++++++++++
 tb/tb_ws2812_uart_strip_router.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_uart_strip_router.sv
// ws2812_uart_strip_router
// Parses {channel, G, R, B} frames from a UART byte stream into per-channel
// pixel registers. Each channel has its own WS2812 serializer. A serializer
// repeatedly sends PIXELS copies of its stored GRB word and then holds the
// line low for the latch gap.
module ws2812_uart_strip_router #(
  parameter int N_CH         = 4,
  parameter int PIXELS       = 8,
  parameter int T_BIT        = 125,
  parameter int T0H          = 40,
  parameter int T1H          = 80,
  parameter int T_RESET      = 5000,
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic            i_clk,
  input  logic            rst_n,
  input  logic            i_rx_dv,
  input  logic [7:0]      i_rx_byte,
  output logic [N_CH-1:0] o_dout,
  output logic [N_CH-1:0] o_ch_update,
  output logic            o_frame_err,
  output logic            o_parser_busy
);

  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TO_W    = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam int CNT_MAX = (T_RESET > T_BIT) ? T_RESET : T_BIT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int PIX_W   = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  typedef enum logic [1:0] {P_IDLE, P_G, P_R, P_B} parser_state_e;
  typedef enum logic       {S_GAP, S_BIT}          ser_state_e;

  parser_state_e   state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [7:0]      g_q, g_d;
  logic [7:0]      r_q, r_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic [N_CH-1:0] upd_q, upd_d;
  logic            err_q, err_d;
  logic [23:0]     pix_q [N_CH];
  logic [23:0]     pix_d [N_CH];

  // Parser next-state: frame assembly, pixel write and inter-byte timeout.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    ch_d    = ch_q;
    g_d     = g_q;
    r_d     = r_q;
    idle_d  = '0;
    upd_d   = '0;
    err_d   = 1'b0;
    pix_d   = pix_q;
    case (state_q)
      P_IDLE: begin
        if (i_rx_dv) begin
          if (int'(i_rx_byte) < N_CH) begin
            ch_d    = i_rx_byte[CH_W-1:0];
            state_d = P_G;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        // A byte arriving on the timeout cycle is taken and the timeout is dropped.
        if (i_rx_dv) begin
          case (state_q)
            P_G: begin
              g_d     = i_rx_byte;
              state_d = P_R;
            end
            P_R: begin
              r_d     = i_rx_byte;
              state_d = P_B;
            end
            default: begin
              pix_d[ch_q] = {g_q, r_q, i_rx_byte};
              upd_d[ch_q] = 1'b1;
              state_d     = P_IDLE;
            end
          endcase
        end else if (idle_q == TO_W'(BYTE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = P_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
    endcase
  end

  // Parser registers, pixel registers and the registered status pulses.
  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      state_q <= P_IDLE;
      ch_q    <= '0;
      g_q     <= '0;
      r_q     <= '0;
      idle_q  <= '0;
      upd_q   <= '0;
      err_q   <= 1'b0;
      // NOTE: the pixel array is a small register file whose contents must start black, so it is reset like any other flop.
      for (int i = 0; i < N_CH; i++) pix_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      g_q     <= g_d;
      r_q     <= r_d;
      idle_q  <= idle_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      pix_q   <= pix_d;
    end
  end

  assign o_ch_update   = upd_q;
  assign o_frame_err   = err_q;
  assign o_parser_busy = (state_q != P_IDLE);

  for (genvar c = 0; c < N_CH; c++) begin : g_ser
    ser_state_e       s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_q, bit_d;
    logic [PIX_W-1:0] px_q, px_d;
    logic [23:0]      shadow_q, shadow_d;
    logic             dout_q, dout_d;

    // Serializer next-state; the data line is computed from the next state so the flop lines up with the counters.
    always_comb begin
      s_d      = s_q;
      cnt_d    = cnt_q + 1'b1;
      bit_d    = bit_q;
      px_d     = px_q;
      shadow_d = shadow_q;
      if (s_q == S_GAP) begin
        if (cnt_q == CNT_W'(T_RESET - 1)) begin
          // The colour is sampled once per refresh, so a mid-refresh write cannot tear the strip.
          s_d      = S_BIT;
          cnt_d    = '0;
          shadow_d = pix_q[c];
          px_d     = '0;
          bit_d    = 5'd23;
        end
      end else if (cnt_q == CNT_W'(T_BIT - 1)) begin
        cnt_d = '0;
        if (bit_q == 5'd0) begin
          bit_d = 5'd23;
          if (px_q == PIX_W'(PIXELS - 1)) begin
            s_d = S_GAP;
          end else begin
            px_d = px_q + 1'b1;
          end
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      dout_d = (s_d == S_BIT) &&
               (cnt_d < (shadow_d[bit_d] ? CNT_W'(T1H) : CNT_W'(T0H)));
    end

    // Serializer registers; reset parks the channel at the start of a latch gap.
    always_ff @(posedge i_clk) begin
      if (!rst_n) begin
        s_q      <= S_GAP;
        cnt_q    <= '0;
        bit_q    <= 5'd23;
        px_q     <= '0;
        shadow_q <= '0;
        dout_q   <= 1'b0;
      end else begin
        s_q      <= s_d;
        cnt_q    <= cnt_d;
        bit_q    <= bit_d;
        px_q     <= px_d;
        shadow_q <= shadow_d;
        dout_q   <= dout_d;
      end
    end

    assign o_dout[c] = dout_q;
  end

endmodule

// File: tb/tb_ws2812_uart_strip_router.sv
// Testbench for ws2812_uart_strip_router: directed and random byte streams,
// with a frame-level parser model and a waveform model built from timing arithmetic.
module tb_ws2812_uart_strip_router;

  localparam int N_CH         = 4;
  localparam int PIXELS       = 2;
  localparam int T_BIT        = 10;
  localparam int T0H          = 3;
  localparam int T1H          = 7;
  localparam int T_RESET      = 20;
  localparam int BYTE_TIMEOUT = 50;
  localparam int PERIOD       = T_RESET + PIXELS * 24 * T_BIT;

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic            rx_dv   = 1'b0;
  logic [7:0]      rx_byte = 8'h00;
  logic [N_CH-1:0] dout;
  logic [N_CH-1:0] ch_update;
  logic            frame_err;
  logic            parser_busy;

  ws2812_uart_strip_router #(
    .N_CH(N_CH), .PIXELS(PIXELS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H),
    .T_RESET(T_RESET), .BYTE_TIMEOUT(BYTE_TIMEOUT)
  ) dut (
    .i_clk(clk), .rst_n(rst_n), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
    .o_dout(dout), .o_ch_update(ch_update), .o_frame_err(frame_err),
    .o_parser_busy(parser_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rst = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct { int cyc; logic [N_CH-1:0] upd; logic err; } evt_t;
  typedef struct { int cyc; logic val; } busy_t;
  typedef struct { int cyc; int ch; logic [23:0] val; } wr_t;

  evt_t  evq[$];
  busy_t bq[$];
  wr_t   wq[$];
  evt_t  ev;

  logic [23:0] model_pix [N_CH];
  logic [23:0] ref_col [N_CH];
  logic [31:0] seg_exp [N_CH];
  logic [31:0] seg_act [N_CH];
  logic        exp_busy = 1'b0;
  int          m_pos = 0;
  int          m_ch = 0;
  logic [7:0]  m_g, m_r;
  int          last_dv = 0;

  // Cycle counter; remembers the last edge that saw reset.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) last_rst = cyc;
  end

  // Monitor: applies model writes, then checks status outputs and each waveform segment.
  always @(negedge clk) begin
    if (started) begin
      while (wq.size() > 0 && wq[0].cyc <= cyc) begin
        model_pix[wq[0].ch] = wq[0].val;
        void'(wq.pop_front());
      end
      while (bq.size() > 0 && bq[0].cyc <= cyc) begin
        exp_busy = bq[0].val;
        void'(bq.pop_front());
      end
      check("parser_busy", parser_busy, exp_busy);

      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev = evq.pop_front();
        check("ch_update", ch_update, ev.upd);
        check("frame_err", frame_err, ev.err);
      end else begin
        check("ch_update_idle", ch_update, '0);
        check("frame_err_idle", frame_err, 1'b0);
      end

      for (int c = 0; c < N_CH; c++) begin
        int ph, b;
        logic e;
        ph = (cyc - last_rst) % PERIOD;
        if (ph == T_RESET - 1) ref_col[c] = model_pix[c];
        if (ph < T_RESET) begin
          e = 1'b0;
          b = 0;
        end else begin
          b = ph - T_RESET;
          e = ((b % T_BIT) < (ref_col[c][23 - ((b / T_BIT) % 24)] ? T1H : T0H));
        end
        if (ph == 0 || (ph >= T_RESET && (b % T_BIT) == 0)) begin
          seg_exp[c] = '0;
          seg_act[c] = '0;
        end
        seg_exp[c] = {seg_exp[c][30:0], e};
        seg_act[c] = {seg_act[c][30:0], dout[c]};
        if (ph == T_RESET - 1 || (ph >= T_RESET && (b % T_BIT) == T_BIT - 1))
          check($sformatf("dout%0d_seg_ph%0d", c, ph), seg_act[c], seg_exp[c]);
      end
    end
  end

  // One idle cycle; also notices when the model's partial frame times out.
  task automatic tick();
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
    if (m_pos != 0 && (cyc - last_dv) == BYTE_TIMEOUT) begin
      evq.push_back('{cyc + 1, {N_CH{1'b0}}, 1'b1});
      bq.push_back('{cyc + 1, 1'b0});
      m_pos = 0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One strobed byte; the frame model decides which response it produces.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    case (m_pos)
      0: begin
        if (int'(b) < N_CH) begin
          m_ch  = int'(b);
          m_pos = 1;
          bq.push_back('{cyc + 1, 1'b1});
        end else begin
          evq.push_back('{cyc + 1, {N_CH{1'b0}}, 1'b1});
        end
      end
      1: begin m_g = b; m_pos = 2; end
      2: begin m_r = b; m_pos = 3; end
      default: begin
        evq.push_back('{cyc + 1, N_CH'(1) << m_ch, 1'b0});
        wq.push_back('{cyc + 1, m_ch, {m_g, m_r, b}});
        bq.push_back('{cyc + 1, 1'b0});
        m_pos = 0;
      end
    endcase
    last_dv = cyc;
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [7:0] g,
                            input logic [7:0] r, input logic [7:0] b);
    send_byte(ch); tick();
    send_byte(g);  tick();
    send_byte(r);  tick();
    send_byte(b);  tick();
  endtask

  // Holds reset across one edge and clears the model to its power-on state.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_dv = 1'b0;
    @(posedge clk);
    #1;
    evq.delete();
    bq.delete();
    wq.delete();
    exp_busy = 1'b0;
    m_pos    = 0;
    for (int c = 0; c < N_CH; c++) begin
      model_pix[c] = '0;
      ref_col[c]   = '0;
    end
    rst_n   = 1'b1;
    started = 1'b1;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i <= PERIOD; i++) begin
      if (((cyc - last_rst) % PERIOD) == p) return;
      tick();
    end
    check("wait_phase_bound", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then black refreshes on every strip.
    repeat (2) @(posedge clk);
    do_reset();
    ticks(2 * PERIOD);

    // Frame to channel 2, observed over two refreshes.
    send_frame(8'h02, 8'hFF, 8'h00, 8'h0F);
    ticks(2 * PERIOD);

    // Bad channel byte, then a valid frame.
    send_byte(8'h07);
    ticks(3);
    send_frame(8'h01, 8'h80, 8'h00, 8'h01);

    // Timeout after 50 idle cycles; then a byte on the timeout cycle continues the frame.
    send_byte(8'h03); tick();
    send_byte(8'hAA);
    ticks(BYTE_TIMEOUT);
    ticks(5);
    send_byte(8'h03); tick();
    send_byte(8'hAA);
    ticks(BYTE_TIMEOUT - 1);
    send_byte(8'h55); ticks(2);
    send_byte(8'h66); tick();

    // Channel 1 rewritten mid-refresh.
    wait_phase(T_RESET + 100);
    send_frame(8'h01, 8'h12, 8'h34, 8'h56);
    ticks(2 * PERIOD);

    // Random byte streams, including bad channels and mid-frame stalls.
    for (int n = 0; n < 30; n++) begin
      int ch;
      ch = $urandom_range(0, 5);
      send_byte(8'(ch));
      if (ch < N_CH) begin
        for (int k = 0; k < 3; k++) begin
          ticks(($urandom_range(0, 9) == 0) ? $urandom_range(45, 55) : $urandom_range(0, 5));
          send_byte(8'($urandom_range(0, 255)));
        end
      end
      ticks($urandom_range(1, 60));
    end
    ticks(2 * PERIOD);

    // Reset in the middle of a frame and of a bit.
    wait_phase(T_RESET + 40);
    send_byte(8'h00); tick();
    send_byte(8'h12);
    do_reset();
    send_byte(8'h12); tick();
    send_byte(8'h34); tick();
    ticks(2 * PERIOD + 10);

    check("events_drained", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
